// File: rtl/fifo_rr_wr_arbiter_if.sv
// Bundle of the producer handshake, flush request and FIFO write-side pins
// shared by fifo_rr_wr_arbiter (master side) and the system around it.
interface fifo_rr_wr_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int DWIDTH = 8
);
   localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]        req_valid;
   logic [NREQ*DWIDTH-1:0] req_data;
   logic [NREQ-1:0]        req_ready;
   logic                   flush_req;
   logic                   flush_ack;
   logic                   fifo_full;
   logic                   fifo_write;
   logic [DWIDTH-1:0]      fifo_data;
   logic                   fifo_flush;
   logic [NREQ-1:0]        grant;
   logic [IDW-1:0]         grant_id;

   // arbiter side
   modport master (
      input  req_valid, req_data, flush_req, fifo_full,
      output req_ready, flush_ack, fifo_write, fifo_data, fifo_flush, grant, grant_id
   );

   // producers, flush controller and FIFO side
   modport slave (
      output req_valid, req_data, flush_req, fifo_full,
      input  req_ready, flush_ack, fifo_write, fifo_data, fifo_flush, grant, grant_id
   );
endinterface

// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready
// producers. A grant lasts at most BURST beats, stalls while the FIFO is full,
// and a flush request is serviced between grants with a one-cycle flush pulse.
module fifo_rr_wr_arbiter #(
   parameter int NREQ   = 4,
   parameter int DWIDTH = 8,
   parameter int BURST  = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   fifo_rr_wr_arbiter_if.master bus
);
   localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;
   localparam int CW  = $clog2(BURST + 1);
   localparam logic [CW-1:0]  LAST_BEAT = CW'(BURST - 1);
   localparam logic [IDW-1:0] LAST_IDX  = IDW'(NREQ - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t            state_r;
   logic [NREQ-1:0]   grant_r;
   logic [IDW-1:0]    grant_id_r;
   logic [IDW-1:0]    rr_r;
   logic [CW-1:0]     beat_r;
   logic              flush_r;

   logic [IDW-1:0]    pick_s;
   logic [NREQ-1:0]   pick_oh_s;
   int                dist_s;
   int                best_d_s;
   logic              take_s;
   logic              gnt_active_s;
   logic              cur_valid_s;
   logic [NREQ-1:0]   ready_s;
   logic              write_s;
   logic [DWIDTH-1:0] sel_s;
   logic [DWIDTH-1:0] data_s;

   // Pick the first valid requester after the rr pointer, wrapping modulo NREQ:
   // the winner is the valid index with the smallest forward distance.
   always_comb begin
      pick_s   = '0;
      best_d_s = NREQ;
      dist_s   = 0;
      take_s   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         dist_s   = (i + NREQ - 1 - int'(rr_r)) % NREQ;
         take_s   = bus.req_valid[i] && (dist_s < best_d_s);
         pick_s   = take_s ? IDW'(i) : pick_s;
         best_d_s = take_s ? dist_s : best_d_s;
      end
      pick_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
   end

   // Ready/write gating and the write-data mux, all keyed off the registered grant.
   always_comb begin
      gnt_active_s = |grant_r;
      cur_valid_s  = |(bus.req_valid & grant_r);
      ready_s      = grant_r & {NREQ{~bus.fifo_full & ~bus.flush_req}};
      write_s      = |(bus.req_valid & ready_s);
      sel_s        = '0;
      for (int i = 0; i < NREQ; i++) begin
         sel_s = sel_s | (bus.req_data[i*DWIDTH +: DWIDTH] & {DWIDTH{grant_r[i]}});
      end
      data_s = gnt_active_s ? sel_s : bus.req_data[DWIDTH-1:0];
   end

   // Arbitration FSM: grant selection, burst counting, release and flush sequencing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         grant_r    <= '0;
         grant_id_r <= '0;
         rr_r       <= LAST_IDX;
         beat_r     <= '0;
         flush_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               flush_r <= 1'b0;
               if (bus.flush_req) begin
                  flush_r <= 1'b1;
                  state_r <= FLUSH;
               end else if (|bus.req_valid) begin
                  grant_r    <= pick_oh_s;
                  grant_id_r <= pick_s;
                  beat_r     <= '0;
                  state_r    <= GRANT;
               end else begin
                  state_r <= IDLE;
               end
            end
            GRANT: begin
               if (bus.flush_req) begin
                  rr_r    <= grant_id_r;
                  grant_r <= '0;
                  beat_r  <= '0;
                  flush_r <= 1'b1;
                  state_r <= FLUSH;
               end else if (write_s && (beat_r == LAST_BEAT)) begin
                  rr_r    <= grant_id_r;
                  grant_r <= '0;
                  beat_r  <= '0;
                  state_r <= IDLE;
               end else if (!cur_valid_s) begin
                  rr_r    <= grant_id_r;
                  grant_r <= '0;
                  beat_r  <= '0;
                  state_r <= IDLE;
               end else if (write_s) begin
                  beat_r <= beat_r + CW'(1);
               end else begin
                  // stalled on full: hold the grant indefinitely
                  beat_r <= beat_r;
               end
            end
            FLUSH: begin
               flush_r <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               grant_r <= '0;
               beat_r  <= '0;
               flush_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant      = grant_r;
   assign bus.grant_id   = grant_id_r;
   assign bus.flush_ack  = flush_r;
   assign bus.fifo_flush = flush_r;
   assign bus.req_ready  = ready_s;
   assign bus.fifo_write = write_s;
   assign bus.fifo_data  = data_s;
endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Directed bench for fifo_rr_wr_arbiter: a 4-producer instance (BURST=4) and a
// 3-producer instance (BURST=2) for the non-power-of-2 wrap case.
module tb_fifo_rr_wr_arbiter;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   fifo_rr_wr_arbiter_if #(.NREQ(4), .DWIDTH(8)) b ();
   fifo_rr_wr_arbiter_if #(.NREQ(3), .DWIDTH(8)) c ();

   fifo_rr_wr_arbiter #(.NREQ(4), .DWIDTH(8), .BURST(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b.master)
   );

   fifo_rr_wr_arbiter #(.NREQ(3), .DWIDTH(8), .BURST(2)) u_dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (c.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance to 2 time units after the next rising edge
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      #1;
      total++; if (b.grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want %b", b.grant, 4'b0000); end
      total++; if (b.grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant_id: got %0d want 0", b.grant_id); end
      total++; if (b.flush_ack !== 1'b0) begin bad++; $display("FAIL reset_flush_ack: got %b want 0", b.flush_ack); end
      total++; if (b.fifo_flush !== 1'b0) begin bad++; $display("FAIL reset_fifo_flush: got %b want 0", b.fifo_flush); end
      total++; if (b.fifo_write !== 1'b0) begin bad++; $display("FAIL reset_fifo_write: got %b want 0", b.fifo_write); end
      total++; if (c.grant !== 3'b000) begin bad++; $display("FAIL reset_grant3: got %b want %b", c.grant, 3'b000); end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g;
      logic [7:0] exp_d;
      for (int i = 0; i < 4; i++) b.req_data[i*8 +: 8] = 8'hB0 + 8'(i);
      b.req_valid = 4'b1111;
      #1;
      total++; if (b.grant !== 4'b0000) begin bad++; $display("FAIL rr_first_idle: got %b want 0000", b.grant); end
      step();
      for (int k = 0; k < 5; k++) begin
         exp_g = 4'b0001 << (k % 4);
         exp_d = 8'hB0 + 8'(k % 4);
         for (int bt = 0; bt < 4; bt++) begin
            #1;
            total++; if (b.grant !== exp_g) begin bad++; $display("FAIL rr_grant k=%0d beat=%0d: got %b want %b", k, bt, b.grant, exp_g); end
            total++; if (b.fifo_write !== 1'b1) begin bad++; $display("FAIL rr_write k=%0d beat=%0d: got %b want 1", k, bt, b.fifo_write); end
            total++; if (b.fifo_data !== exp_d) begin bad++; $display("FAIL rr_data k=%0d beat=%0d: got %h want %h", k, bt, b.fifo_data, exp_d); end
            step();
         end
         if (k == 4) b.req_valid = 4'b0000;
         #1;
         total++; if (b.grant !== 4'b0000) begin bad++; $display("FAIL rr_idle_gap k=%0d: got %b want 0000", k, b.grant); end
         total++; if (b.fifo_write !== 1'b0) begin bad++; $display("FAIL rr_idle_write k=%0d: got %b want 0", k, b.fifo_write); end
         step();
      end
   endtask

   task automatic test_single();
      logic [7:0] exp_d;
      b.req_valid      = 4'b0010;
      b.req_data[15:8] = 8'hA1;
      #1;
      total++; if (b.grant !== 4'b0000) begin bad++; $display("FAIL single_cycle0_grant: got %b want 0000", b.grant); end
      step();
      for (int k = 0; k < 3; k++) begin
         exp_d = 8'hA1 + 8'(k);
         b.req_data[15:8] = exp_d;
         #1;
         total++; if (b.grant !== 4'b0010) begin bad++; $display("FAIL single_grant beat=%0d: got %b want 0010", k, b.grant); end
         total++; if (b.fifo_write !== 1'b1) begin bad++; $display("FAIL single_write beat=%0d: got %b want 1", k, b.fifo_write); end
         total++; if (b.fifo_data !== exp_d) begin bad++; $display("FAIL single_data beat=%0d: got %h want %h", k, b.fifo_data, exp_d); end
         step();
      end
      b.req_valid = 4'b0000;
      #1;
      total++; if (b.fifo_write !== 1'b0) begin bad++; $display("FAIL single_drop_write: got %b want 0", b.fifo_write); end
      total++; if (b.req_ready !== 4'b0010) begin bad++; $display("FAIL single_drop_ready: got %b want 0010", b.req_ready); end
      step();
      #1;
      total++; if (b.grant !== 4'b0000) begin bad++; $display("FAIL single_release: got %b want 0000", b.grant); end
      total++; if (b.grant_id !== 2'd1) begin bad++; $display("FAIL single_hold_id: got %0d want 1", b.grant_id); end
      step();
   endtask

   task automatic test_flush();
      b.req_data[23:16] = 8'hD1;
      b.req_data[31:24] = 8'hD3;
      b.req_valid       = 4'b0100;
      #1;
      step();
      #1;
      total++; if (b.grant !== 4'b0100) begin bad++; $display("FAIL flush_pre_grant: got %b want 0100", b.grant); end
      total++; if (b.fifo_write !== 1'b1) begin bad++; $display("FAIL flush_beat1_write: got %b want 1", b.fifo_write); end
      step();
      b.req_data[23:16] = 8'hD2;
      b.req_valid       = 4'b1100;
      b.flush_req       = 1'b1;
      #1;
      total++; if (b.fifo_write !== 1'b0) begin bad++; $display("FAIL flush_no_write: got %b want 0", b.fifo_write); end
      total++; if (b.req_ready !== 4'b0000) begin bad++; $display("FAIL flush_no_ready: got %b want 0000", b.req_ready); end
      total++; if (b.fifo_flush !== 1'b0) begin bad++; $display("FAIL flush_early: got %b want 0", b.fifo_flush); end
      step();
      #1;
      total++; if (b.fifo_flush !== 1'b1) begin bad++; $display("FAIL flush_pulse: got %b want 1", b.fifo_flush); end
      total++; if (b.flush_ack !== 1'b1) begin bad++; $display("FAIL flush_ack: got %b want 1", b.flush_ack); end
      total++; if (b.grant !== 4'b0000) begin bad++; $display("FAIL flush_grant: got %b want 0000", b.grant); end
      b.flush_req = 1'b0;
      step();
      #1;
      total++; if (b.fifo_flush !== 1'b0) begin bad++; $display("FAIL flush_one_cycle: got %b want 0", b.fifo_flush); end
      total++; if (b.flush_ack !== 1'b0) begin bad++; $display("FAIL flush_ack_one_cycle: got %b want 0", b.flush_ack); end
      total++; if (b.grant !== 4'b0000) begin bad++; $display("FAIL flush_idle_grant: got %b want 0000", b.grant); end
      step();
      #1;
      total++; if (b.grant !== 4'b1000) begin bad++; $display("FAIL flush_next_grant: got %b want 1000", b.grant); end
      total++; if (b.grant_id !== 2'd3) begin bad++; $display("FAIL flush_next_id: got %0d want 3", b.grant_id); end
      total++; if (b.fifo_data !== 8'hD3) begin bad++; $display("FAIL flush_next_data: got %h want d3", b.fifo_data); end
      b.req_valid = 4'b0000;
      step();
      step();
   endtask

   task automatic test_full_stall();
      int         beats;
      logic       exp_w;
      logic [7:0] exp_d;
      beats       = 0;
      b.req_valid = 4'b0100;
      b.req_data[23:16] = 8'hC1;
      #1;
      step();
      for (int cyc = 0; cyc < 7; cyc++) begin
         b.fifo_full = (cyc >= 2 && cyc <= 4) ? 1'b1 : 1'b0;
         exp_d = 8'hC1 + 8'(beats);
         b.req_data[23:16] = exp_d;
         exp_w = ~b.fifo_full;
         #1;
         total++; if (b.grant !== 4'b0100) begin bad++; $display("FAIL full_grant cyc=%0d: got %b want 0100", cyc, b.grant); end
         total++; if (b.fifo_write !== exp_w) begin bad++; $display("FAIL full_write cyc=%0d: got %b want %b", cyc, b.fifo_write, exp_w); end
         total++; if (b.req_ready !== (exp_w ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL full_ready cyc=%0d: got %b want %b", cyc, b.req_ready, (exp_w ? 4'b0100 : 4'b0000)); end
         if (b.fifo_write === 1'b1) begin
            total++; if (b.fifo_data !== exp_d) begin bad++; $display("FAIL full_data cyc=%0d: got %h want %h", cyc, b.fifo_data, exp_d); end
            beats++;
         end
         step();
      end
      b.fifo_full = 1'b0;
      b.req_valid = 4'b0000;
      #1;
      total++; if (b.grant !== 4'b0000) begin bad++; $display("FAIL full_burst_end: got %b want 0000", b.grant); end
      total++; if (b.grant_id !== 2'd2) begin bad++; $display("FAIL full_hold_id: got %0d want 2", b.grant_id); end
      total++; if (beats != 4) begin bad++; $display("FAIL full_beats: got %0d want 4", beats); end
      step();
   endtask

   task automatic test_nreq3_wrap();
      c.req_data[7:0]   = 8'hE0;
      c.req_data[23:16] = 8'hE2;
      c.req_valid       = 3'b101;
      #1;
      total++; if (c.grant !== 3'b000) begin bad++; $display("FAIL wrap_idle: got %b want 000", c.grant); end
      step();
      #1;
      total++; if (c.grant !== 3'b001) begin bad++; $display("FAIL wrap_grant: got %b want 001", c.grant); end
      total++; if (c.grant_id !== 2'd0) begin bad++; $display("FAIL wrap_id: got %0d want 0", c.grant_id); end
      total++; if (c.fifo_data !== 8'hE0) begin bad++; $display("FAIL wrap_data: got %h want e0", c.fifo_data); end
      step();
      #1;
      total++; if (c.fifo_write !== 1'b1) begin bad++; $display("FAIL wrap_beat2: got %b want 1", c.fifo_write); end
      step();
      #1;
      total++; if (c.grant !== 3'b000) begin bad++; $display("FAIL wrap_burst_end: got %b want 000", c.grant); end
      step();
      #1;
      total++; if (c.grant !== 3'b100) begin bad++; $display("FAIL wrap_second_grant: got %b want 100", c.grant); end
      total++; if (c.fifo_data !== 8'hE2) begin bad++; $display("FAIL wrap_second_data: got %h want e2", c.fifo_data); end
      c.req_valid = 3'b000;
      step();
      step();
   endtask

   task automatic test_reset_mid_burst();
      b.req_data[15:8] = 8'h55;
      b.req_valid      = 4'b0010;
      #1;
      step();
      #1;
      total++; if (b.grant !== 4'b0010) begin bad++; $display("FAIL rstmid_grant: got %b want 0010", b.grant); end
      step();
      rst_n = 1'b0;
      #1;
      total++; if (b.grant !== 4'b0000) begin bad++; $display("FAIL rstmid_grant_cleared: got %b want 0000", b.grant); end
      total++; if (b.fifo_write !== 1'b0) begin bad++; $display("FAIL rstmid_write: got %b want 0", b.fifo_write); end
      total++; if (b.req_ready !== 4'b0000) begin bad++; $display("FAIL rstmid_ready: got %b want 0000", b.req_ready); end
      total++; if (b.grant_id !== 2'd0) begin bad++; $display("FAIL rstmid_id: got %0d want 0", b.grant_id); end
      step();
      rst_n       = 1'b1;
      b.req_valid = 4'b1111;
      #1;
      step();
      #1;
      total++; if (b.grant !== 4'b0001) begin bad++; $display("FAIL rstmid_first_grant: got %b want 0001", b.grant); end
      b.req_valid = 4'b0000;
      step();
      step();
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      rst_n       = 1'b0;
      b.req_valid = '0;
      b.req_data  = '0;
      b.flush_req = 1'b0;
      b.fifo_full = 1'b0;
      c.req_valid = '0;
      c.req_data  = '0;
      c.flush_req = 1'b0;
      c.fifo_full = 1'b0;
      test_reset();
      test_round_robin();
      test_single();
      test_flush();
      test_full_stall();
      test_nreq3_wrap();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule

// File: doc/fifo_rr_wr_arbiter.md
Name: fifo_rr_wr_arbiter

Overview:
- Shares the write port of one `fifo` instance among NREQ producers using round-robin arbitration with bounded bursts.
- Each producer uses a valid/ready handshake.
- The arbiter drives the FIFO `write_i`, `data_i` and `flush_i` pins and never writes into a full FIFO.
- A flush request port lets the system controller empty the FIFO between grants in a clean way.

Parameters:
- NREQ, 4: number of producers, 2..8.
- DWIDTH, 8: data width; matches the FIFO DWIDTH.
- BURST, 4: maximum beats written per grant, 1..16.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid_i  in  NREQ  per-producer valid.
- req_data_i  in  NREQ*DWIDTH  per-producer data; producer i uses bits [i*DWIDTH +: DWIDTH].
- req_ready_o  out  NREQ  per-producer ready.
- flush_req_i  in  1  level request to flush the FIFO.
- flush_ack_o  out  1  one-cycle pulse when the flush is issued.
- fifo_full_i  in  1  from FIFO `full_o`.
- fifo_write_o  out  1  to FIFO `write_i`.
- fifo_data_o  out  DWIDTH  to FIFO `data_i`.
- fifo_flush_o  out  1  to FIFO `flush_i`.
- grant_o  out  NREQ  one-hot current grant; 0 when none.
- grant_id_o  out  max(1,$clog2(NREQ))  index of the granted producer; holds its last value when no grant is active.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, grant_o=0, grant_id_o=0, beat counter=0.
  - rr pointer (last granted index) = NREQ-1, so producer 0 wins first.
  - flush_ack_o=0, fifo_flush_o=0.
  - Reset asserted mid-burst aborts the burst immediately; no partial state is retained.
- State machine: IDLE, GRANT, FLUSH.
- IDLE:
  - If flush_req_i=1, go to FLUSH. Flush has priority over arbitration.
  - Otherwise, if any req_valid_i is set, select the first set bit searching from rr pointer+1 upward, with wrap-around.
  - Register grant_o/grant_id_o, clear the beat counter, go to GRANT.
  - Arbitration latency is one cycle: a grant is visible the cycle after valid is seen in IDLE.
- GRANT, ready and write:
  - req_ready_o[g] = grant_o[g] & ~fifo_full_i & ~flush_req_i. All other ready bits are 0.
  - fifo_write_o = req_valid_i[g] & req_ready_o[g], combinational.
  - fifo_data_o = req_data_i slice g. It is don't-care when no write occurs, but is driven from the granted slice, or slice 0 when no grant is active.
  - Each write increments the beat counter. No increment occurs while stalled on full.
- GRANT, exit conditions (first matching rule wins):
  - flush_req_i=1: no write this cycle; rr pointer = g; go to FLUSH.
  - A write occurs and beat counter+1 == BURST: rr pointer = g; go to IDLE.
  - req_valid_i[g]=0: release; rr pointer = g; go to IDLE.
  - fifo_full_i=1: hold the grant with no timeout; resume when full deasserts.
- Every release spends one cycle in IDLE with grant_o=0.
- FLUSH: fifo_flush_o=1 and flush_ack_o=1 for exactly one cycle, then go to IDLE.
  - If flush_req_i is still high on return to IDLE, another flush is issued. The requester drops flush_req_i on seeing the ack.
- Producers hold valid and data stable until ready; a beat transfers when valid & ready.
- FIFO full timing: `full` is registered in the FIFO, so back-to-back writes are legal until fifo_full_i rises. The FIFO `read_i` is not driven by this block.
- Widths: the beat counter is $clog2(BURST+1) bits. The rr pointer and grant_id_o are max(1,$clog2(NREQ)) bits, with wrap computed modulo NREQ, not a power of 2.

Test Plan:
- Producer 1 valid alone with data 0xA1,0xA2,0xA3 at cycle 0 -> grant_o=0010 at cycle 1; writes at cycles 1,2,3 in order; valid drops -> IDLE, grant_o=0 at cycle 5.
- All 4 producers continuously valid, BURST=4, fifo_full_i=0 -> grants 0,1,2,3,0, each exactly 4 writes, one idle cycle between grants.
- fifo_full_i high after beat 2 for 3 cycles -> fifo_write_o=0 and ready=0 during the stall; grant held; beats 3-4 written after full drops; total 4 beats.
- flush_req_i asserted during beat 2 of producer 2 -> no write that cycle; next cycle fifo_flush_o=flush_ack_o=1 for 1 cycle; then producer 3 is granted next.
- NREQ=3, producers 2 and 0 valid, rr pointer=2 -> producer 0 granted (wrap at 3, not 4).
- rst_n asserted mid-burst -> grant_o=0, fifo_write_o=0 immediately; after release, producer 0 is granted first.
